ro_deser: RTL and testbench

- Downstream of ro_block_1 through ro_block_N: consumes the shared tri-stated readout lines out_mux_eve / out_mux_pol_eve.
- Each master cycle, exactly one readout block drives the lines. That block is the channel whose gray-count bit toggled on the preceding rising edge.
- ro_deser mirrors the gray counter with a binary counter, captures the bus and tags each event with channel index, polarity and timestamp.
- Tagged events are buffered in a FIFO for a valid/ready consumer.

---
 rtl/ro_deser.sv | 171 +++++++++++++++++
 tb/tb_ro_deser.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ro_deser.sv
// Readout deserializer: mirrors the gray counter with a binary count, captures the
// shared readout lines in the high phase and queues tagged events in a show-ahead FIFO.
module ro_deser #(
  parameter int N_CH  = 19,
  parameter int CH_W  = 5,
  parameter int TS_W  = 19,
  parameter int DEPTH = 8
) (
  input  logic                     clk_master,
  input  logic                     rstb,
  input  logic                     bus_eve,
  input  logic                     bus_pol_eve,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [CH_W-1:0]          out_chan,
  output logic                     out_pol,
  output logic [TS_W-1:0]          out_ts,
  output logic                     overflow,
  output logic [$clog2(DEPTH):0]   fill
);

  localparam int AW     = $clog2(DEPTH);
  localparam int FILL_W = AW + 1;
  localparam int EW     = CH_W + 1 + TS_W;
  localparam int BW     = (N_CH > TS_W) ? N_CH : TS_W;

  // Lowest set bit of the next count names the toggling gray bit; zero means wrap (MSB toggles).
  function automatic logic [CH_W-1:0] active_chan(input logic [N_CH-1:0] nxt);
    logic [CH_W-1:0] c;
    c = CH_W'(N_CH);
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (nxt[i]) begin
        c = CH_W'(i + 1);
      end else begin
        c = c;
      end
    end
    return c;
  endfunction

  logic [N_CH-1:0]  b_r;
  logic [N_CH-1:0]  b_nxt_s;
  logic [BW-1:0]    b_ext_s;
  logic [TS_W-1:0]  ts_s;
  logic [CH_W-1:0]  chan_s;

  logic [CH_W-1:0]  pend_chan_r;
  logic [TS_W-1:0]  pend_ts_r;
  logic             pend_vld_r;
  logic             cap_eve_r;
  logic             cap_pol_r;

  logic [EW-1:0]    mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [FILL_W-1:0] fill_r;
  logic             overflow_r;

  logic             full_s;
  logic             pop_s;
  logic             push_req_s;
  logic             push_s;
  logic             drop_s;
  logic [EW-1:0]    head_s;

  // Next mirror count and the tags for the slot it opens.
  always_comb begin
    b_nxt_s = b_r + N_CH'(1'b1);
    b_ext_s = BW'(b_nxt_s);
    ts_s    = b_ext_s[TS_W-1:0];
    chan_s  = active_chan(b_nxt_s);
  end

  // Mirror counter and pending tags for the slot being driven this high phase.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      b_r         <= {N_CH{1'b0}};
      pend_chan_r <= {CH_W{1'b0}};
      pend_ts_r   <= {TS_W{1'b0}};
      pend_vld_r  <= 1'b0;
    end else begin
      b_r         <= b_nxt_s;
      pend_chan_r <= chan_s;
      pend_ts_r   <= ts_s;
      pend_vld_r  <= 1'b1;
    end
  end

  // Falling-edge sample of the shared lines; anything not a solid 1 reads as 0.
  always_ff @(negedge clk_master or negedge rstb) begin
    if (!rstb) begin
      cap_eve_r <= 1'b0;
      cap_pol_r <= 1'b0;
    end else begin
      if (bus_eve == 1'b1) begin
        cap_eve_r <= 1'b1;
      end else begin
        cap_eve_r <= 1'b0;
      end
      if (bus_pol_eve == 1'b1) begin
        cap_pol_r <= 1'b1;
      end else begin
        cap_pol_r <= 1'b0;
      end
    end
  end

  // A pop in the same cycle frees the slot, so a full FIFO still accepts the push.
  always_comb begin
    full_s     = (fill_r == FILL_W'(DEPTH));
    pop_s      = (fill_r != {FILL_W{1'b0}}) & out_ready;
    push_req_s = pend_vld_r & cap_eve_r;
    push_s     = push_req_s & (~full_s | pop_s);
    drop_s     = push_req_s & full_s & ~pop_s;
  end

  // FIFO pointers, occupancy and sticky drop flag.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      fill_r     <= {FILL_W{1'b0}};
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1'b1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1'b1);
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   fill_r <= fill_r + FILL_W'(1'b1);
        2'b01:   fill_r <= fill_r - FILL_W'(1'b1);
        default: fill_r <= fill_r;
      endcase
      if (drop_s) begin
        overflow_r <= 1'b1;
      end else begin
        overflow_r <= overflow_r;
      end
    end
  end

  // Event storage.
  always_ff @(posedge clk_master or negedge rstb) begin
    if (!rstb) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {EW{1'b0}};
      end
    end else begin
      if (push_s) begin
        mem_r[wr_ptr_r] <= {pend_chan_r, cap_pol_r, pend_ts_r};
      end else begin
        mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
      end
    end
  end

  assign head_s    = mem_r[rd_ptr_r];
  assign out_valid = (fill_r != {FILL_W{1'b0}});
  assign out_chan  = out_valid ? head_s[EW-1 -: CH_W] : {CH_W{1'b0}};
  assign out_pol   = out_valid ? head_s[TS_W] : 1'b0;
  assign out_ts    = out_valid ? head_s[TS_W-1:0] : {TS_W{1'b0}};
  assign overflow  = overflow_r;
  assign fill      = fill_r;

endmodule

// File: tb/tb_ro_deser.sv
// Bench for ro_deser: queue-based event model checked every falling edge, plus
// directed scenarios with hand-computed expectations (second instance covers wrap).
module tb_ro_deser;

  localparam int N_CH = 19, CH_W = 5, TS_W = 19, DEPTH = 8;

  logic clk_master = 1'b0;
  always #5 clk_master = ~clk_master;

  logic rstb = 1'b0, bus_eve = 1'b0, bus_pol_eve = 1'b0, out_ready = 1'b0;
  logic out_valid, out_pol, overflow;
  logic [CH_W-1:0] out_chan;
  logic [TS_W-1:0] out_ts;
  logic [3:0] fill;

  logic rstb2 = 1'b0, bus2 = 1'b1, pol2 = 1'b0, ready2 = 1'b1;
  logic valid2, opol2, ovf2;
  logic [2:0] chan2;
  logic [3:0] ts2;
  logic [3:0] fill2;

  ro_deser #(.N_CH(N_CH), .CH_W(CH_W), .TS_W(TS_W), .DEPTH(DEPTH)) dut (
    .clk_master(clk_master), .rstb(rstb), .bus_eve(bus_eve), .bus_pol_eve(bus_pol_eve),
    .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .out_pol(out_pol),
    .out_ts(out_ts), .overflow(overflow), .fill(fill));

  ro_deser #(.N_CH(4), .CH_W(3), .TS_W(4), .DEPTH(8)) dut_w (
    .clk_master(clk_master), .rstb(rstb2), .bus_eve(bus2), .bus_pol_eve(pol2),
    .out_valid(valid2), .out_ready(ready2), .out_chan(chan2), .out_pol(opol2),
    .out_ts(ts2), .overflow(ovf2), .fill(fill2));

  int n_checks = 0, n_fail = 0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int chan_of(input longint v, input int n);
    if (v == 0) return n;
    for (int i = 0; i < n; i++) if (v[i]) return i + 1;
    return n;
  endfunction

  typedef struct {int chan; int pol; longint ts;} ev_t;
  ev_t mq[$];
  ev_t log1[$];
  ev_t log2[$];

  longint mb;
  bit m_pv, m_cap, m_cpol, m_rdy, m_ovf, pe_live, pop_m;
  int m_pchan;
  longint m_pts;

  always @(posedge clk_master) pe_live <= rstb;

  // Model: replay the posedge that just happened, then compare all outputs.
  always @(negedge clk_master) begin
    if (!rstb) begin
      mq.delete(); mb = 0; m_pv = 0; m_cap = 0; m_ovf = 0; m_rdy = 0;
      check("rst_valid", out_valid, 0);
      check("rst_fill", fill, 0);
      check("rst_overflow", overflow, 0);
    end else begin
      if (pe_live) begin
        pop_m = (mq.size() > 0) && m_rdy;
        if (pop_m) void'(mq.pop_front());
        if (m_cap && m_pv) begin
          if (mq.size() < DEPTH) mq.push_back('{m_pchan, int'(m_cpol), m_pts});
          else m_ovf = 1;
        end
        mb = (mb + 1) % (64'd1 << N_CH);
        m_pchan = chan_of(mb, N_CH);
        m_pts = mb & ((64'd1 << TS_W) - 1);
        m_pv = 1;
        check("m_valid", out_valid, (mq.size() > 0) ? 1 : 0);
        check("m_fill", fill, mq.size());
        check("m_overflow", overflow, m_ovf);
        if (mq.size() > 0) begin
          check("m_chan", out_chan, mq[0].chan);
          check("m_pol", out_pol, mq[0].pol);
          check("m_ts", out_ts, mq[0].ts);
        end
      end
      m_cap = (bus_eve === 1'b1);
      m_cpol = (bus_pol_eve === 1'b1);
      m_rdy = out_ready;
      if (out_valid && out_ready) log1.push_back('{int'(out_chan), int'(out_pol), longint'(out_ts)});
    end
  end

  always @(negedge clk_master) begin
    if (rstb2 && valid2 && ready2) log2.push_back('{int'(chan2), int'(opol2), longint'(ts2)});
  end

  task automatic tick();
    @(posedge clk_master);
    #1;
  endtask

  int exp_ch[8] = '{1, 2, 1, 3, 1, 2, 1, 4};
  logic [15:0] pat;
  int s_chan, s_pol, s_ts;
  bit found;

  initial begin
    // Reset state and channel sequence
    repeat (3) tick();
    check("reset_valid", out_valid, 0);
    check("reset_chan", out_chan, 0);
    check("reset_ts", out_ts, 0);
    check("reset_fill", fill, 0);
    bus_eve = 1'b1; bus_pol_eve = 1'b0; out_ready = 1'b1; rstb = 1'b1;
    log1.delete();
    repeat (12) tick();
    check("seq_count_ge8", (log1.size() >= 8) ? 1 : 0, 1);
    if (log1.size() >= 8) begin
      for (int i = 0; i < 8; i++) begin
        check("seq_chan", log1[i].chan, exp_ch[i]);
        check("seq_ts", log1[i].ts, i + 1);
        check("seq_pol", log1[i].pol, 0);
      end
    end

    // Latency: single event in slot b 4->5
    rstb = 1'b0; bus_eve = 1'b0; tick();
    rstb = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      check("lat_idle_before", out_valid, 0);
    end
    bus_eve = 1'b1;
    tick();
    bus_eve = 1'b0;
    check("lat_valid", out_valid, 1);
    check("lat_chan", out_chan, 1);
    check("lat_ts", out_ts, 5);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("lat_idle_after", out_valid, 0);
    end

    // Overflow
    rstb = 1'b0; tick();
    bus_eve = 1'b1; out_ready = 1'b0; rstb = 1'b1;
    repeat (9) tick();
    check("ovf_fill8", fill, 8);
    check("ovf_not_yet", overflow, 0);
    tick();
    check("ovf_fill_held", fill, 8);
    check("ovf_set", overflow, 1);
    check("ovf_head_chan", out_chan, 1);
    check("ovf_head_ts", out_ts, 1);
    out_ready = 1'b1;
    repeat (5) tick();
    check("ovf_fill_stream", fill, 8);
    check("ovf_sticky", overflow, 1);

    // Polarity and backpressure
    rstb = 1'b0; tick();
    bus_eve = 1'b1; bus_pol_eve = 1'b0; out_ready = 1'b1; rstb = 1'b1;
    log1.delete();
    pat = 16'hB4D3;
    for (int i = 1; i <= 14; i++) begin
      tick();
      bus_pol_eve = pat[i];
      if (i == 4) begin
        out_ready = 1'b0;
        s_chan = int'(out_chan); s_pol = int'(out_pol); s_ts = int'(out_ts);
      end
      if (i >= 5 && i <= 7) begin
        check("bp_valid", out_valid, 1);
        check("bp_chan_stable", out_chan, s_chan);
        check("bp_pol_stable", out_pol, s_pol);
        check("bp_ts_stable", out_ts, s_ts);
      end
      if (i == 7) out_ready = 1'b1;
    end
    tick();
    bus_eve = 1'b0;
    repeat (12) tick();
    check("pol_count", log1.size(), 14);
    if (log1.size() == 14) begin
      for (int j = 0; j < 14; j++) begin
        check("pol_ts", log1[j].ts, j + 1);
        check("pol_seq", log1[j].pol, int'(pat[j+1]));
      end
    end

    // Reset mid-run
    rstb = 1'b0; tick();
    bus_eve = 1'b1; out_ready = 1'b0; rstb = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (fill == 4'd5) break;
    end
    check("mid_fill5", fill, 5);
    rstb = 1'b0;
    #1;
    check("mid_async_valid", out_valid, 0);
    check("mid_async_fill", fill, 0);
    check("mid_async_ovf", overflow, 0);
    tick();
    out_ready = 1'b1; rstb = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (out_valid) begin
        found = 1'b1;
        break;
      end
    end
    check("mid_first_seen", found, 1);
    check("mid_first_chan", out_chan, 1);
    check("mid_first_ts", out_ts, 1);

    // Wrap on the 4-channel instance
    rstb2 = 1'b1;
    log2.delete();
    repeat (22) tick();
    check("wrap_count_ge17", (log2.size() >= 17) ? 1 : 0, 1);
    if (log2.size() >= 17) begin
      for (int j = 0; j < 17; j++) begin
        check("wrap_chan", log2[j].chan, chan_of((j + 1) % 16, 4));
        check("wrap_ts", log2[j].ts, (j + 1) % 16);
      end
      check("wrap_lit_chan", log2[15].chan, 4);
      check("wrap_lit_ts", log2[15].ts, 0);
      check("wrap_next_chan", log2[16].chan, 1);
      check("wrap_next_ts", log2[16].ts, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
